// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared phase encodings, lamp codes and default durations for the intersection controller
package traffic_pkg;

    typedef enum logic [2:0] {
        MG  = 3'd0,
        MY  = 3'd1,
        AR1 = 3'd2,
        SG  = 3'd3,
        SY  = 3'd4,
        AR2 = 3'd5
    } phase_t;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    localparam int DEF_MIN_GREEN  = 8;
    localparam int DEF_SIDE_GREEN = 6;
    localparam int DEF_YELLOW_T   = 3;
    localparam int DEF_ALLRED_T   = 2;
    localparam int DEF_CNT_W      = 8;

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - tick-gated saturating phase timer with clear and duration compare
module phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             clr,
    input  logic [CNT_W:0]   dur,
    output logic             done,
    output logic             elapsed
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   last;

    assign last = dur - 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (tick && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // elapsed stays true once the minimum is reached; saturation keeps it from wrapping false
    assign done    = tick && ({1'b0, cnt} == last);
    assign elapsed = tick && ({1'b0, cnt} >= last);

endmodule

// File: rtl/intersection_phase_ctrl.sv
// rtl/intersection_phase_ctrl.sv - two-road phase sequencer; PED_WALK_EN adds ped_req/walk
module intersection_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN  = DEF_MIN_GREEN,
    parameter int SIDE_GREEN = DEF_SIDE_GREEN,
    parameter int YELLOW_T   = DEF_YELLOW_T,
    parameter int ALLRED_T   = DEF_ALLRED_T,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       side_req,
`ifdef PED_WALK_EN
    input  logic       ped_req,
    output logic       walk,
`endif
    output logic [2:0] main_lights,
    output logic [2:0] side_lights,
    output logic [2:0] phase,
    output logic       req_pending
);

    phase_t         state;
    phase_t         state_nx;
    logic [CNT_W:0] dur;
    logic           done;
    logic           elapsed;
    logic           enter_sg;
    logic           req_any;

    always_comb begin
        dur = (CNT_W+1)'(ALLRED_T);
        case (state)
            MG:      dur = (CNT_W+1)'(MIN_GREEN);
            MY, SY:  dur = (CNT_W+1)'(YELLOW_T);
            SG:      dur = (CNT_W+1)'(SIDE_GREEN);
            default: dur = (CNT_W+1)'(ALLRED_T);
        endcase
    end

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick),
        .clr     (state_nx != state),
        .dur     (dur),
        .done    (done),
        .elapsed (elapsed)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= MG;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            MG:      if (elapsed && req_pending) state_nx = MY;
            MY:      if (done) state_nx = AR1;
            AR1:     if (done) state_nx = SG;
            SG:      if (done) state_nx = SY;
            SY:      if (done) state_nx = AR2;
            AR2:     if (done) state_nx = MG;
            default: state_nx = AR2;
        endcase
    end

`ifdef PED_WALK_EN
    assign req_any = side_req | ped_req;
`else
    assign req_any = side_req;
`endif

    assign enter_sg = (state_nx == SG) && (state != SG);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_pending <= 1'b0;
        end else if (enter_sg) begin
            req_pending <= 1'b0;
        end else if (req_any && (state != SG)) begin
            req_pending <= 1'b1;
        end
    end

`ifdef PED_WALK_EN
    logic ped_latched;

    // walk samples the latch on SG entry so it stays steady for the whole side green
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ped_latched <= 1'b0;
            walk        <= 1'b0;
        end else if ((state == SG) && (state_nx != SG)) begin
            ped_latched <= 1'b0;
            walk        <= 1'b0;
        end else begin
            if (enter_sg) walk <= ped_latched;
            if (ped_req && (state != SG)) ped_latched <= 1'b1;
        end
    end
`endif

    always_comb begin
        main_lights = LAMP_RED;
        side_lights = LAMP_RED;
        case (state)
            MG:      main_lights = LAMP_GRN;
            MY:      main_lights = LAMP_YEL;
            SG:      side_lights = LAMP_GRN;
            SY:      side_lights = LAMP_YEL;
            default: ;
        endcase
    end

    assign phase = state;

endmodule

// File: tb/tb_intersection_phase_ctrl.sv
// tb/tb_intersection_phase_ctrl.sv - directed self-checking bench for intersection_phase_ctrl
module tb_intersection_phase_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b1;
    logic       side_req = 1'b0;
    logic [2:0] main_lights;
    logic [2:0] side_lights;
    logic [2:0] phase;
    logic       req_pending;

    int n_cmp  = 0;
    int n_fail = 0;

    intersection_phase_ctrl #(
        .MIN_GREEN  (4),
        .SIDE_GREEN (3),
        .YELLOW_T   (2),
        .ALLRED_T   (1),
        .CNT_W      (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .side_req    (side_req),
        .main_lights (main_lights),
        .side_lights (side_lights),
        .phase       (phase),
        .req_pending (req_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [2:0] main_of(input int p);
        return (p == 0) ? 3'b001 : (p == 1) ? 3'b010 : 3'b100;
    endfunction

    function automatic logic [2:0] side_of(input int p);
        return (p == 3) ? 3'b001 : (p == 4) ? 3'b010 : 3'b100;
    endfunction

    task automatic check_lamps(input string tag, input int exp_p);
        chk({tag, "_phase"}, {5'b0, phase}, 8'(exp_p));
        chk({tag, "_main"}, {5'b0, main_lights}, {5'b0, main_of(exp_p)});
        chk({tag, "_side"}, {5'b0, side_lights}, {5'b0, side_of(exp_p)});
        chk({tag, "_both_green"}, {7'b0, main_lights[0] & side_lights[0]}, 8'd0);
    endtask

    task automatic step(input int exp_p);
        @(posedge clk);
        #1;
        check_lamps("step", exp_p);
    endtask

    int dur_tab[6] = '{4, 2, 1, 3, 2, 1};
    int exp_seq[6] = '{1, 2, 3, 4, 5, 0};

    initial begin
        int prev;
        int idx;
        int t_last;
        bit fin;

        #2;
        check_lamps("reset", 0);
        chk("reset_pending", {7'b0, req_pending}, 8'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < 50; i++) step(0);
        chk("idle_pending", {7'b0, req_pending}, 8'd0);

        side_req = 1'b1;
        step(0);
        side_req = 1'b0;
        chk("late_req_pending", {7'b0, req_pending}, 8'd1);
        step(1);
        step(1);
        step(2);
        step(3);
        chk("sg_entry_clear", {7'b0, req_pending}, 8'd0);
        side_req = 1'b1;
        step(3);
        side_req = 1'b0;
        chk("sg_req_ignored", {7'b0, req_pending}, 8'd0);
        step(3);
        step(4);
        side_req = 1'b1;
        step(4);
        side_req = 1'b0;
        chk("sy_req_latched", {7'b0, req_pending}, 8'd1);
        step(5);
        step(0);
        step(0);
        step(0);
        step(0);
        step(1);
        step(1);
        step(2);
        step(3);
        chk("sg_reentry_clear", {7'b0, req_pending}, 8'd0);

        #3;
        rst = 1'b0;
        #1;
        check_lamps("async_rst", 0);
        chk("async_rst_pending", {7'b0, req_pending}, 8'd0);
        @(posedge clk);
        #1;
        chk("rst_held_phase", {5'b0, phase}, 8'd0);
        rst = 1'b1;

        side_req = 1'b1;
        step(0);
        side_req = 1'b0;
        chk("c1_pending", {7'b0, req_pending}, 8'd1);
        step(0);
        step(0);
        step(1);
        step(1);
        step(2);
        step(3);
        chk("c1_sg_clear", {7'b0, req_pending}, 8'd0);
        step(3);
        step(3);
        step(4);
        step(4);
        step(5);
        step(0);

        tick = 1'b0;
        side_req = 1'b1;
        step(0);
        side_req = 1'b0;
        prev = 0;
        idx = 0;
        t_last = 0;
        fin = 1'b0;
        for (int c = 1; c <= 300 && !fin; c++) begin
            tick = ((c % 3) == 1);
            @(posedge clk);
            #1;
            chk("gated_both_green", {7'b0, main_lights[0] & side_lights[0]}, 8'd0);
            if (int'(phase) != prev) begin
                chk("gated_seq", {5'b0, phase}, 8'(exp_seq[idx]));
                if (idx > 0) chk("gated_dwell", 8'(c - t_last), 8'(3 * dur_tab[prev]));
                t_last = c;
                prev = int'(phase);
                idx++;
                if (idx == 6) fin = 1'b1;
            end
        end
        chk("gated_complete", 8'(idx), 8'd6);
        tick = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
